// File: rtl/icap_pkg.sv
// Shared types, error codes and the ICAP bit-swap helper for the ICAP wrapper.
package icap_pkg;

    localparam int ICAP_WORD_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_WAIT_DONE,
        ST_FLUSH,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_PRERROR = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    // ICAP expects the bits of every byte in reversed order.
    function automatic logic [ICAP_WORD_W-1:0] icap_bitswap32(input logic [ICAP_WORD_W-1:0] x);
        logic [ICAP_WORD_W-1:0] y;
        for (int b = 0; b < ICAP_WORD_W / 8; b++) begin
            for (int i = 0; i < 8; i++) begin
                y[8*b+i] = x[8*b+7-i];
            end
        end
        return y;
    endfunction

endpackage

// File: rtl/icap_bitstream_feeder_if.sv
// Bitstream word stream (valid/ready with last marker) feeding the ICAP path.
interface icap_bitstream_feeder_if;
    import icap_pkg::*;

    logic [ICAP_WORD_W-1:0] tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/icap_timeout_cnt.sv
// Watchdog counter: counts enabled cycles and flags when TIMEOUT_CYCLES-1 is reached.
module icap_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int            TW    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] count;

    // Count up while enabled, holding at the terminal value until cleared
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + TW'(1);
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/icap_bitstream_feeder.sv
// Streams a partial bitstream into the ICAP write port and reports transfer status.
module icap_bitstream_feeder
    import icap_pkg::*;
#(
    parameter int SWAP_BITS      = 1,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int CNT_W          = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic                     abort,
    icap_bitstream_feeder_if.slave   s,
    output logic                     ICAP_CSIB,
    output logic [ICAP_WORD_W-1:0]   ICAP_I,
    output logic                     ICAP_RDWRB,
    input  logic                     ICAP_AVAIL,
    input  logic                     ICAP_PRDONE,
    input  logic                     ICAP_PRERROR,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [1:0]               err_code,
    output logic [CNT_W-1:0]         word_cnt
);

    state_t                 state, state_nxt;
    logic                   accept;
    logic                   wr_en, clr_xfer, set_done, set_error, set_code;
    logic [1:0]             code_nxt;
    logic                   tmo_clear, tmo_enable, tmo_expired;
    logic [ICAP_WORD_W-1:0] wdata;

    assign accept     = s.tvalid && s.tready;
    assign wdata      = (SWAP_BITS != 0) ? icap_bitswap32(s.tdata) : s.tdata;
    assign ICAP_RDWRB = 1'b0;
    assign busy       = (state == ST_WRITE) || (state == ST_WAIT_DONE) || (state == ST_FLUSH);

    icap_timeout_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (CLK),
        .rst     (RST),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, stream handshake and event decode (PRERROR > abort > timeout > PRDONE > accept)
    always_comb begin
        state_nxt  = state;
        s.tready   = 1'b0;
        wr_en      = 1'b0;
        clr_xfer   = 1'b0;
        set_done   = 1'b0;
        set_error  = 1'b0;
        set_code   = 1'b0;
        code_nxt   = ERR_NONE;
        tmo_clear  = 1'b0;
        tmo_enable = 1'b0;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_nxt = ST_WRITE;
                    clr_xfer  = 1'b1;
                    tmo_clear = 1'b1;
                end
            end
            ST_WRITE: begin
                s.tready   = ICAP_AVAIL;
                tmo_clear  = ICAP_AVAIL;
                tmo_enable = !ICAP_AVAIL;
                if (ICAP_PRERROR || abort) begin
                    set_code = 1'b1;
                    code_nxt = ICAP_PRERROR ? ERR_PRERROR : ERR_ABORT;
                    // A last word handshaken in the error cycle still closes the bitstream.
                    if (accept && s.tlast) begin
                        state_nxt = ST_ERROR;
                        set_error = 1'b1;
                    end else begin
                        state_nxt = ST_FLUSH;
                    end
                end else if (tmo_expired) begin
                    state_nxt = ST_ERROR;
                    set_error = 1'b1;
                    set_code  = 1'b1;
                    code_nxt  = ERR_TIMEOUT;
                end else if (accept) begin
                    wr_en = 1'b1;
                    if (s.tlast) begin
                        state_nxt = ST_WAIT_DONE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                tmo_enable = 1'b1;
                if (ICAP_PRERROR || abort) begin
                    state_nxt = ST_ERROR;
                    set_error = 1'b1;
                    set_code  = 1'b1;
                    code_nxt  = ICAP_PRERROR ? ERR_PRERROR : ERR_ABORT;
                end else if (tmo_expired) begin
                    state_nxt = ST_ERROR;
                    set_error = 1'b1;
                    set_code  = 1'b1;
                    code_nxt  = ERR_TIMEOUT;
                end else if (ICAP_PRDONE) begin
                    state_nxt = ST_DONE;
                    set_done  = 1'b1;
                end
            end
            ST_FLUSH: begin
                s.tready = 1'b1;
                if (abort || (accept && s.tlast)) begin
                    state_nxt = ST_ERROR;
                    set_error = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // ICAP write port: one registered cycle from stream accept to the pins
    always_ff @(posedge CLK) begin
        if (RST) begin
            ICAP_CSIB <= 1'b1;
            ICAP_I    <= '0;
        end else begin
            ICAP_CSIB <= !wr_en;
            if (wr_en) begin
                ICAP_I <= wdata;
            end
        end
    end

    // Sticky status flags and saturating word counter
    always_ff @(posedge CLK) begin
        if (RST || clr_xfer) begin
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            word_cnt <= '0;
        end else begin
            if (set_done) begin
                done <= 1'b1;
            end
            if (set_error) begin
                error <= 1'b1;
            end
            if (set_code) begin
                err_code <= code_nxt;
            end
            if (wr_en && (word_cnt != '1)) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_icap_bitstream_feeder.sv
// Randomized and directed bench for icap_bitstream_feeder against a transfer-level reference model.
module tb_icap_bitstream_feeder;
    import icap_pkg::*;

    localparam int TMO     = 16;
    localparam int CNT_PTW = 3;

    // Model phases of a transfer
    localparam int P_IDLE = 0, P_STREAM = 1, P_WAIT = 2, P_DRAIN = 3, P_OK = 4, P_FAIL = 5;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic start = 1'b0, abort = 1'b0, avail = 1'b1, prdone = 1'b0, prerror = 1'b0;

    icap_bitstream_feeder_if sif ();
    icap_bitstream_feeder_if sif_pt ();

    assign sif_pt.tdata  = sif.tdata;
    assign sif_pt.tvalid = sif.tvalid;
    assign sif_pt.tlast  = sif.tlast;

    logic        csib, rdwrb, busy, done, error;
    logic [31:0] icap_i, word_cnt;
    logic [1:0]  err_code;

    logic               csib_pt, rdwrb_pt, busy_pt, done_pt, error_pt;
    logic [31:0]        icap_i_pt;
    logic [1:0]         err_code_pt;
    logic [CNT_PTW-1:0] word_cnt_pt;

    icap_bitstream_feeder #(.SWAP_BITS(1), .TIMEOUT_CYCLES(TMO), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .s(sif.slave),
        .ICAP_CSIB(csib), .ICAP_I(icap_i), .ICAP_RDWRB(rdwrb),
        .ICAP_AVAIL(avail), .ICAP_PRDONE(prdone), .ICAP_PRERROR(prerror),
        .busy(busy), .done(done), .error(error), .err_code(err_code), .word_cnt(word_cnt)
    );

    icap_bitstream_feeder #(.SWAP_BITS(0), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_PTW)) dut_pt (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .s(sif_pt.slave),
        .ICAP_CSIB(csib_pt), .ICAP_I(icap_i_pt), .ICAP_RDWRB(rdwrb_pt),
        .ICAP_AVAIL(avail), .ICAP_PRDONE(prdone), .ICAP_PRERROR(prerror),
        .busy(busy_pt), .done(done_pt), .error(error_pt), .err_code(err_code_pt), .word_cnt(word_cnt_pt)
    );

    // Reference model state
    int          ph     = P_IDLE;
    int unsigned m_cnt  = 0;
    int          m_tmo  = 0;
    bit          m_done = 1'b0, m_err = 1'b0, m_csib = 1'b1;
    logic [1:0]  m_code = 2'b00;
    logic [31:0] m_i = '0, m_i_raw = '0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic logic [31:0] ref_swap(input logic [31:0] x);
        logic [31:0] y;
        for (int k = 0; k < 32; k++) y[k] = x[(k / 8) * 8 + 7 - (k % 8)];
        return y;
    endfunction

    function automatic bit exp_tready();
        if (ph == P_STREAM) return avail;
        return (ph == P_DRAIN);
    endfunction

    function automatic logic [63:0] sat_cnt();
        return (m_cnt > 7) ? 64'd7 : 64'(m_cnt);
    endfunction

    // Advance the model across one clock edge using the inputs currently applied
    task automatic model_edge();
        bit acc, wr;
        acc = sif.tvalid && exp_tready();
        wr  = 1'b0;
        if (RST) begin
            ph = P_IDLE; m_cnt = 0; m_tmo = 0; m_done = 0; m_err = 0; m_code = 2'b00;
            m_i = '0; m_i_raw = '0;
        end else begin
            case (ph)
                P_IDLE, P_OK, P_FAIL: begin
                    if (start) begin
                        ph = P_STREAM; m_cnt = 0; m_tmo = 0; m_done = 0; m_err = 0; m_code = 2'b00;
                    end
                end
                P_STREAM: begin
                    if (prerror || abort) begin
                        m_code = prerror ? 2'b01 : 2'b11;
                        if (acc && sif.tlast) begin ph = P_FAIL; m_err = 1; end
                        else ph = P_DRAIN;
                    end else if (m_tmo == TMO - 1) begin
                        ph = P_FAIL; m_err = 1; m_code = 2'b10;
                    end else if (acc) begin
                        wr = 1'b1;
                        if (sif.tlast) ph = P_WAIT;
                    end
                    m_tmo = avail ? 0 : m_tmo + 1;
                end
                P_WAIT: begin
                    if (prerror || abort) begin
                        ph = P_FAIL; m_err = 1; m_code = prerror ? 2'b01 : 2'b11;
                    end else if (m_tmo == TMO - 1) begin
                        ph = P_FAIL; m_err = 1; m_code = 2'b10;
                    end else if (prdone) begin
                        ph = P_OK; m_done = 1;
                    end else begin
                        m_tmo++;
                    end
                end
                P_DRAIN: begin
                    if (abort || (acc && sif.tlast)) begin ph = P_FAIL; m_err = 1; end
                end
                default: ph = P_IDLE;
            endcase
        end
        if (wr) begin
            m_i     = ref_swap(sif.tdata);
            m_i_raw = sif.tdata;
            if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
        end
        m_csib = !wr;
    endtask

    task automatic check_outputs();
        bit exp_busy;
        exp_busy = (ph == P_STREAM) || (ph == P_WAIT) || (ph == P_DRAIN);
        check_val("csib", csib, m_csib);
        check_val("icap_i", icap_i, m_i);
        check_val("rdwrb", rdwrb, 0);
        check_val("busy", busy, exp_busy);
        check_val("done", done, m_done);
        check_val("error", error, m_err);
        check_val("err_code", err_code, m_code);
        check_val("word_cnt", word_cnt, m_cnt);
        check_val("pt_csib", csib_pt, m_csib);
        check_val("pt_icap_i", icap_i_pt, m_i_raw);
        check_val("pt_rdwrb", rdwrb_pt, 0);
        check_val("pt_busy", busy_pt, exp_busy);
        check_val("pt_done", done_pt, m_done);
        check_val("pt_error", error_pt, m_err);
        check_val("pt_err_code", err_code_pt, m_code);
        check_val("pt_word_cnt_sat", word_cnt_pt, sat_cnt());
    endtask

    // One clock: apply inputs, check the handshake, step model, check registered outputs
    task automatic cycle(input bit r, input bit st, input bit ab, input bit v, input bit l,
                         input logic [31:0] d, input bit av, input bit pd, input bit pe);
        RST = r; start = st; abort = ab; sif.tvalid = v; sif.tlast = l; sif.tdata = d;
        avail = av; prdone = pd; prerror = pe;
        #1;
        check_val("tready", sif.tready, exp_tready());
        check_val("pt_tready", sif_pt.tready, exp_tready());
        model_edge();
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, 0, 32'h0, 1, 0, 0);
    endtask

    task automatic send(input logic [31:0] d, input bit l);
        cycle(0, 0, 0, 1, l, d, 1, 0, 0);
    endtask

    task automatic go();
        cycle(0, 1, 0, 0, 0, 32'h0, 1, 0, 0);
    endtask

    task automatic pulse_prdone();
        cycle(0, 0, 0, 0, 0, 32'h0, 1, 1, 0);
    endtask

    initial begin
        int          n;
        logic [31:0] w;
        sif.tdata = '0; sif.tvalid = 1'b0; sif.tlast = 1'b0;
        RST = 1'b1;
        repeat (3) @(posedge CLK);
        #1;

        // Reset state
        check_val("rst_csib", csib, 1);
        check_val("rst_icap_i", icap_i, 0);
        check_val("rst_tready", sif.tready, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_error", error, 0);
        check_val("rst_err_code", err_code, 0);
        check_val("rst_word_cnt", word_cnt, 0);

        // Basic transfer with bit swap
        go();
        send(32'h000000BB, 0); check_val("t1_csib0", csib, 0); check_val("t1_w0", icap_i, 32'h000000DD);
        send(32'h11220044, 0); check_val("t1_w1", icap_i, 32'h88440022);
        send(32'hFFFFFFFF, 0); check_val("t1_w2", icap_i, 32'hFFFFFFFF);
        send(32'hAA995566, 1); check_val("t1_w3", icap_i, 32'h5599AA66); check_val("t1_csib3", csib, 0);
        idle(10);
        check_val("t1_csib_idle", csib, 1);
        pulse_prdone();
        check_val("t1_word_cnt", word_cnt, 4);
        check_val("t1_done", done, 1);
        check_val("t1_error", error, 0);

        // AVAIL stall mid-stream
        go();
        send(32'h01020304, 0); send(32'h05060708, 0); send(32'h090A0B0C, 0);
        for (int k = 0; k < 5; k++) begin
            cycle(0, 0, 0, 1, 0, 32'hCAFEF00D, 0, 0, 0);
            check_val("t2_stall_csib", csib, 1);
        end
        send(32'hCAFEF00D, 0); check_val("t2_w3", icap_i, ref_swap(32'hCAFEF00D));
        send(32'h13572468, 0); send(32'h80000001, 1);
        pulse_prdone();
        check_val("t2_word_cnt", word_cnt, 6);
        check_val("t2_error", error, 0);
        check_val("t2_done", done, 1);

        // PRERROR after word 2 of 6
        go();
        send(32'h11111111, 0); send(32'h22222222, 0);
        cycle(0, 0, 0, 1, 0, 32'h33333333, 1, 0, 1);
        check_val("t3_csib", csib, 1);
        check_val("t3_err_code", err_code, 2'b01);
        check_val("t3_err_before_last", error, 0);
        send(32'h44444444, 0); send(32'h55555555, 0); send(32'h66666666, 1);
        check_val("t3_error", error, 1);
        check_val("t3_err_code_end", err_code, 2'b01);
        check_val("t3_word_cnt", word_cnt, 2);
        check_val("t3_busy", busy, 0);

        // Timeout in WAIT_DONE
        go();
        send(32'hA5A5A5A5, 0); send(32'h5A5A5A5A, 1);
        n = 0;
        while (busy && n < 40) begin idle(1); n++; end
        check_val("t4_wait_cycles", n, 16);
        check_val("t4_err_code", err_code, 2'b10);
        check_val("t4_busy", busy, 0);
        check_val("t4_error", error, 1);

        // Abort coinciding with an accept
        go();
        send(32'h0F0F0F0F, 0);
        cycle(0, 0, 1, 1, 0, 32'h12121212, 1, 0, 0);
        check_val("t5_csib", csib, 1);
        check_val("t5_i_hold", icap_i, 32'hF0F0F0F0);
        check_val("t5_word_cnt", word_cnt, 1);
        check_val("t5_err_code", err_code, 2'b11);
        send(32'h34343434, 1);
        check_val("t5_error", error, 1);

        // Reset in the middle of WRITE
        go();
        send(32'h76543210, 0); send(32'hFEDCBA98, 0);
        cycle(1, 0, 0, 1, 0, 32'h0BADF00D, 1, 0, 0);
        check_val("t5r_csib", csib, 1);
        check_val("t5r_icap_i", icap_i, 0);
        check_val("t5r_word_cnt", word_cnt, 0);
        check_val("t5r_busy", busy, 0);
        check_val("t5r_error", error, 0);
        check_val("t5r_err_code", err_code, 0);
        idle(2);

        // Pass-through instance versus swapping instance
        go();
        send(32'h12345678, 1);
        check_val("t6_pass", icap_i_pt, 32'h12345678);
        check_val("t6_swap", icap_i, 32'h482C6A1E);
        pulse_prdone();

        // Word counter saturation on the narrow-counter instance
        go();
        for (int k = 0; k < 9; k++) send($urandom, 0);
        send($urandom, 1);
        check_val("sat_word_cnt", word_cnt, 10);
        check_val("sat_word_cnt_pt", word_cnt_pt, 7);
        pulse_prdone();

        // Randomized traffic
        for (int k = 0; k < 3000; k++) begin
            w = $urandom;
            cycle(($urandom % 400) == 0, ($urandom % 10) == 0, ($urandom % 60) == 0,
                  ($urandom % 4) != 0, ($urandom % 5) == 0, w,
                  ($urandom % 8) != 0, ($urandom % 10) == 0, ($urandom % 70) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
